hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage core. It is the driver side of the write-enable/flush pair that every pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB) consumes. Each cycle it decides, per latch, whether to advance, hold or insert a bubble. It also holds a small state machine for data-memory waits and the terminal halt, plus a saturating stall-cycle counter for performance debug.

## Interface
- CNT_W, 16, width of stall counter

- CLK  in  1  core clock
- RST  in  1  synchronous reset, active-high
- ihit  in  1  instruction fetch completes this cycle
- dhit  in  1  data access completes this cycle
- memREQ  in  1  EX/MEM latch holds a load or store (exmem DRE|DWE)
- memHALT  in  1  EX/MEM latch holds HALT
- exDRE  in  1  ID/EX latch holds a load
- exWEN  in  1  ID/EX instruction writes a register
- exdest  in  5  ID/EX destination register (after RegDst/JAL select)
- idrs, idrt  in  5 each  source registers of instruction in IF/ID
- iduses_rt  in  1  IF/ID instruction reads rt
- brnch_take  in  1  taken branch, J, JAL or JR resolved in EX
- pcW  out  1  PC load enable
- ifidW, idexW, exmemW, memwbW  out  1 each  latch write enables
- ifidRST, idexRST, exmemRST  out  1 each  synchronous bubble insert (NOP, all control low)
- mem_busy  out  1  FSM in DWAIT
- halted  out  1  FSM in HALT
- stall_cnt  out  CNT_W  stall cycles counted since reset

## Operation
- States: RUN, DWAIT, HALT. The FSM is registered. Outputs are combinational from the state and the current inputs.
- Define freeze = memREQ & !dhit.
- Define loaduse = exDRE & exWEN & (exdest != 0) & ((exdest == idrs) | (iduses_rt & exdest == idrt)).
- In RUN or DWAIT, the first matching rule in this priority order applies:
  1. memHALT: memwbW=1, exmemRST=1, every other enable 0. Next state HALT.
  2. freeze: every enable and every RST 0. Next state DWAIT. stall_cnt increments.
  3. brnch_take: pcW=1, ifidRST=1, idexRST=1, exmemW=1, memwbW=1, ifidW=idexW=0. Next state RUN.
  4. loaduse: pcW=0, ifidW=0, idexRST=1, exmemW=1, memwbW=1. Next state RUN. stall_cnt increments.
  5. !ihit: pcW=0, ifidRST=1, idexW=1, exmemW=1, memwbW=1. Next state RUN.
  6. Otherwise: pcW and all W =1, all RST =0. Next state RUN.
- A latch never sees W=1 and RST=1 together. The RST outputs are one-hot per stage.
- DWAIT produces the same outputs as RUN. It exists only to drive mem_busy and to mark a wait that spans multiple cycles. The cycle in which dhit rises resolves through rules 3–6 with freeze=0, then the FSM returns to RUN.
- HALT: every enable and RST is 0 and halted=1. HALT is sticky and only RST exits it. No input is evaluated in HALT.
- stall_cnt increments by 1 on each freeze or loaduse cycle. It saturates at all-ones and does not wrap. It holds in HALT.
- memHALT coinciding with freeze: rule 1 wins. A HALT in EX/MEM never has memREQ set, so this case is a don't-care for the datapath, but the priority is still fixed.
- brnch_take coinciding with loaduse: the branch wins. The stalled ID instruction is squashed, so no stall is needed.
- brnch_take with !ihit: pcW=1 anyway and the target is loaded. The abandoned fetch is dropped via ifidRST.

## Timing
- Reset cycle (RST=1): state is set to RUN, stall_cnt to 0, halted and mem_busy to 0. Outputs during RST are pcW=0, all W=0, and ifidRST=idexRST=exmemRST=1, which flushes the latches on the same edge.
- Reset asserted mid-operation, including in DWAIT or HALT, takes effect at the next edge with the same values.
- Enable latency is 0 cycles, meaning enables apply at the edge that ends the current cycle. mem_busy and halted lag the triggering input by 1 cycle.
- A load-use stall lasts exactly 1 cycle. After the bubble, the load is in MEM, so loaduse drops naturally.
- A data wait of N cycles (dhit low for N cycles, then high) gives N freeze cycles and mem_busy high for N cycles.

## Test plan
- Reset: hold RST for 2 cycles. Require stall_cnt=0, halted=0, all three RST outputs=1 and pcW=0 during reset. On the first cycle after, with ihit=1, every W is 1.
- Load-use: set exDRE=1, exWEN=1, exdest=5, idrs=5, ihit=1. Require pcW=0, ifidW=0, idexRST=1, stall_cnt +1. On the next cycle, with exDRE=0, all W are 1.
- Zero destination: repeat the load-use case with exdest=0 (idrs=0). Require no stall and all W=1.
- Data wait: memREQ=1 with dhit low for 3 cycles, then high. Require 3 cycles with all outputs 0, mem_busy high on cycles 2–4, stall_cnt +3, and normal advance on the dhit cycle.
- Branch over load-use: brnch_take=1 together with loaduse true. Require pcW=1, ifidRST=1, idexRST=1, and stall_cnt unchanged.
- Halt: memHALT=1. Require memwbW=1 and exmemRST=1 that cycle, then halted=1 and all outputs 0 indefinitely regardless of ihit/dhit, until RST clears it.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard and stall controller for the 5-stage core. Each cycle it
// decides, for every pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB), whether
// that latch advances, holds or takes a bubble. A small FSM tracks
// data-memory waits and the terminal halt. A saturating counter records
// stall cycles for performance debug.
//
// Ports
//   CLK, RST               core clock, synchronous active-high reset
//   ihit, dhit             instruction fetch / data access completes this cycle
//   memREQ, memHALT        EX/MEM latch holds a load/store, or holds HALT
//   exDRE, exWEN, exdest   ID/EX load flag, register-write flag, destination
//   idrs, idrt, iduses_rt  IF/ID source registers and rt-use flag
//   brnch_take             taken branch/jump resolved in EX
//   pcW, *W                PC and latch write enables
//   ifidRST..exmemRST      bubble inserts (one-hot per stage, never with W)
//   mem_busy, halted       FSM in DWAIT / HALT (registered)
//   stall_cnt              saturating count of freeze and load-use cycles
//
// States
//   RUN   | normal operation
//   DWAIT | data access outstanding, pipeline frozen
//   HALT  | terminal halt, only RST leaves it

module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             memREQ,
    input  logic             memHALT,
    input  logic             exDRE,
    input  logic             exWEN,
    input  logic [4:0]       exdest,
    input  logic [4:0]       idrs,
    input  logic [4:0]       idrt,
    input  logic             iduses_rt,
    input  logic             brnch_take,
    output logic             pcW,
    output logic             ifidW,
    output logic             idexW,
    output logic             exmemW,
    output logic             memwbW,
    output logic             ifidRST,
    output logic             idexRST,
    output logic             exmemRST,
    output logic             mem_busy,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;
    logic   freeze;
    logic   loaduse;
    logic   count_stall;

    assign freeze  = memREQ & ~dhit;
    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    assign loaduse = exDRE & exWEN & (exdest != 5'd0) &
                     ((exdest == idrs) | (iduses_rt & (exdest == idrt)));

    always_comb begin
        pcW         = 1'b0;
        ifidW       = 1'b0;
        idexW       = 1'b0;
        exmemW      = 1'b0;
        memwbW      = 1'b0;
        ifidRST     = 1'b0;
        idexRST     = 1'b0;
        exmemRST    = 1'b0;
        count_stall = 1'b0;
        state_nx    = state;

        if (RST) begin
            // Flush every latch on the same edge that resets the FSM.
            ifidRST  = 1'b1;
            idexRST  = 1'b1;
            exmemRST = 1'b1;
            state_nx = RUN;
        end else if (state == HALT) begin
            state_nx = HALT;
        end else if (memHALT) begin
            // Let HALT retire into MEM/WB, bubble behind it.
            memwbW   = 1'b1;
            exmemRST = 1'b1;
            state_nx = HALT;
        end else if (freeze) begin
            count_stall = 1'b1;
            state_nx    = DWAIT;
        end else if (brnch_take) begin
            // Branch squashes IF/ID and ID/EX, which also covers any load-use
            // hazard against the squashed instruction.
            pcW      = 1'b1;
            ifidRST  = 1'b1;
            idexRST  = 1'b1;
            exmemW   = 1'b1;
            memwbW   = 1'b1;
            state_nx = RUN;
        end else if (loaduse) begin
            idexRST     = 1'b1;
            exmemW      = 1'b1;
            memwbW      = 1'b1;
            count_stall = 1'b1;
            state_nx    = RUN;
        end else if (!ihit) begin
            ifidRST  = 1'b1;
            idexW    = 1'b1;
            exmemW   = 1'b1;
            memwbW   = 1'b1;
            state_nx = RUN;
        end else begin
            pcW      = 1'b1;
            ifidW    = 1'b1;
            idexW    = 1'b1;
            exmemW   = 1'b1;
            memwbW   = 1'b1;
            state_nx = RUN;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            mem_busy  <= 1'b0;
            halted    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            state    <= state_nx;
            mem_busy <= (state_nx == DWAIT);
            halted   <= (state_nx == HALT);
            if (count_stall && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed vectors with literal expectations, a
// short random soak, and a rule-table model checked on every falling edge.

module tb_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RST;
    logic             ihit, dhit, memREQ, memHALT, exDRE, exWEN, iduses_rt, brnch_take;
    logic [4:0]       exdest, idrs, idrt;
    logic             pcW, ifidW, idexW, exmemW, memwbW;
    logic             ifidRST, idexRST, exmemRST, mem_busy, halted;
    logic [CNT_W-1:0] stall_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .memREQ(memREQ),
        .memHALT(memHALT), .exDRE(exDRE), .exWEN(exWEN), .exdest(exdest),
        .idrs(idrs), .idrt(idrt), .iduses_rt(iduses_rt), .brnch_take(brnch_take),
        .pcW(pcW), .ifidW(ifidW), .idexW(idexW), .exmemW(exmemW), .memwbW(memwbW),
        .ifidRST(ifidRST), .idexRST(idexRST), .exmemRST(exmemRST),
        .mem_busy(mem_busy), .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    // {pcW, ifidW, idexW, exmemW, memwbW, ifidRST, idexRST, exmemRST}
    wire [7:0] outvec = {pcW, ifidW, idexW, exmemW, memwbW, ifidRST, idexRST, exmemRST};

    // ---------------- behavioural model ----------------
    // Rule ids: 0 reset, 1 halt retire, 2 freeze, 3 branch, 4 load-use,
    // 5 fetch miss, 6 advance, 7 parked in HALT.
    bit m_known = 0;
    bit m_halt  = 0;
    bit m_busy  = 0;
    int m_cnt   = 0;

    function automatic int rule_now();
        bit lu;
        lu = exDRE && exWEN && (exdest != 0) &&
             ((exdest == idrs) || (iduses_rt && (exdest == idrt)));
        if (RST)                 return 0;
        if (m_halt)              return 7;
        if (memHALT)             return 1;
        if (memREQ && !dhit)     return 2;
        if (brnch_take)          return 3;
        if (lu)                  return 4;
        if (!ihit)               return 5;
        return 6;
    endfunction

    function automatic logic [7:0] pat_of(int r);
        case (r)
            0:       return 8'b00000_111;
            1:       return 8'b00001_001;
            3:       return 8'b10011_110;
            4:       return 8'b00011_010;
            5:       return 8'b00111_100;
            6:       return 8'b11111_000;
            default: return 8'b00000_000;
        endcase
    endfunction

    always @(posedge CLK) begin
        int r;
        r = rule_now();
        if (RST) begin
            m_known = 1; m_halt = 0; m_busy = 0; m_cnt = 0;
        end else if (m_known) begin
            if (r == 1) m_halt = 1;
            m_busy = (r == 2);
            if ((r == 2 || r == 4) && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
    end

    always @(negedge CLK) begin
        logic [7:0] e;
        if (RST || m_known) begin
            e = pat_of(rule_now());
            n_cmp++;
            if (outvec !== e) begin
                n_fail++;
                $display("FAIL model_enables t=%0t actual=%b required=%b", $time, outvec, e);
            end
        end
        if (m_known) begin
            n_cmp++;
            if (stall_cnt !== m_cnt[CNT_W-1:0]) begin
                n_fail++;
                $display("FAIL model_stall_cnt t=%0t actual=%0d required=%0d", $time, stall_cnt, m_cnt);
            end
            n_cmp++;
            if ({mem_busy, halted} !== {m_busy, m_halt}) begin
                n_fail++;
                $display("FAIL model_busy_halted t=%0t actual=%b%b required=%b%b",
                         $time, mem_busy, halted, m_busy, m_halt);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
        end
    endtask

    task automatic idle();
        RST = 0; ihit = 1; dhit = 0; memREQ = 0; memHALT = 0; exDRE = 0; exWEN = 0;
        iduses_rt = 0; brnch_take = 0; exdest = 0; idrs = 0; idrt = 0;
    endtask

    // Advance to just after the next rising edge; inputs change there.
    task automatic tick();
        @(posedge CLK); #1;
    endtask

    initial begin
        idle();
        RST = 1;
        #2;
        chk("rst_enables", 32'(outvec), 32'h07);
        tick();
        chk("rst_cnt", 32'(stall_cnt), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_enables2", 32'(outvec), 32'h07);
        tick();
        RST = 0; #1;
        chk("post_rst_advance", 32'(outvec), 32'hF8);
        tick();

        // load-use on rs
        exDRE = 1; exWEN = 1; exdest = 5; idrs = 5; #1;
        chk("loaduse_enables", 32'(outvec), 32'h1A);
        tick();
        chk("loaduse_cnt", 32'(stall_cnt), 1);
        exDRE = 0; #1;
        chk("after_loaduse", 32'(outvec), 32'hF8);
        tick();

        // zero destination never stalls
        exDRE = 1; exdest = 0; idrs = 0; #1;
        chk("zero_dest", 32'(outvec), 32'hF8);
        tick();
        chk("zero_dest_cnt", 32'(stall_cnt), 1);

        // rt hazard only counts when rt is read
        exdest = 7; idrs = 3; idrt = 7; iduses_rt = 0; #1;
        chk("rt_unused", 32'(outvec), 32'hF8);
        tick();
        iduses_rt = 1; #1;
        chk("rt_used", 32'(outvec), 32'h1A);
        tick();
        chk("rt_used_cnt", 32'(stall_cnt), 2);
        idle();

        // three-cycle data wait
        memREQ = 1; dhit = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("dwait_frozen", 32'(outvec), 32'h00);
            chk("dwait_busy", 32'(mem_busy), (i == 0) ? 0 : 1);
            tick();
        end
        dhit = 1; #1;
        chk("dwait_release", 32'(outvec), 32'hF8);
        chk("dwait_release_busy", 32'(mem_busy), 1);
        chk("dwait_cnt", 32'(stall_cnt), 5);
        tick();
        idle(); #1;
        chk("dwait_done_busy", 32'(mem_busy), 0);

        // branch beats load-use
        exDRE = 1; exWEN = 1; exdest = 9; idrs = 9; brnch_take = 1; #1;
        chk("branch_over_lu", 32'(outvec), 32'h9E);
        tick();
        chk("branch_over_lu_cnt", 32'(stall_cnt), 5);
        idle(); brnch_take = 1; ihit = 0; #1;
        chk("branch_miss", 32'(outvec), 32'h9E);
        tick();
        brnch_take = 0; #1;
        chk("fetch_miss", 32'(outvec), 32'h3C);
        tick();
        idle();

        // saturate the counter with a long wait
        memREQ = 1; dhit = 0;
        for (int i = 0; i < 12; i++) tick();
        chk("sat_cnt", 32'(stall_cnt), CNT_MAX);
        dhit = 1; exDRE = 1; exWEN = 1; exdest = 4; idrs = 4; memREQ = 0; #1;
        chk("sat_lu", 32'(outvec), 32'h1A);
        tick();
        chk("sat_hold", 32'(stall_cnt), CNT_MAX);

        // reset out of DWAIT
        idle(); memREQ = 1; tick();
        RST = 1; tick();
        chk("rst_dwait_busy", 32'(mem_busy), 0);
        chk("rst_dwait_cnt", 32'(stall_cnt), 0);
        idle();

        // halt coinciding with freeze, then sticky
        memHALT = 1; memREQ = 1; dhit = 0; #1;
        chk("halt_retire", 32'(outvec), 32'h09);
        tick();
        for (int i = 0; i < 6; i++) begin
            ihit = 1'($urandom); dhit = 1'($urandom); memREQ = 1; memHALT = 1'($urandom);
            exDRE = 1; exWEN = 1; exdest = 2; idrs = 2; brnch_take = 1'($urandom); #1;
            chk("halt_outputs", 32'(outvec), 32'h00);
            chk("halt_flag", 32'(halted), 1);
            tick();
        end
        chk("halt_cnt", 32'(stall_cnt), 0);
        RST = 1; #1;
        chk("halt_rst_enables", 32'(outvec), 32'h07);
        tick();
        chk("halt_cleared", 32'(halted), 0);
        idle();

        // random soak, checked only by the model
        for (int i = 0; i < 400; i++) begin
            RST        = ($urandom_range(0, 60) == 0);
            memHALT    = ($urandom_range(0, 40) == 0);
            memREQ     = 1'($urandom);
            dhit       = 1'($urandom);
            ihit       = ($urandom_range(0, 3) != 0);
            exDRE      = 1'($urandom);
            exWEN      = 1'($urandom);
            iduses_rt  = 1'($urandom);
            brnch_take = ($urandom_range(0, 4) == 0);
            exdest     = 5'($urandom_range(0, 3));
            idrs       = 5'($urandom_range(0, 3));
            idrt       = 5'($urandom_range(0, 3));
            tick();
        end
        idle();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
